// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch engine feeding the IF/ID register; one
//            outstanding req/ack read and a one-entry instruction buffer.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction_out
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_inst_buf;
  logic [31:0] r_target;
  logic        r_imem_req;
  logic        w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_START;
      r_req_addr <= RESET_PC;
      r_inst_buf <= 32'h0;
      r_target   <= 32'h0;
      r_imem_req <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_state    <= ST_FETCH;
          r_req_addr <= RESET_PC;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack && !branch_taken) begin
            r_inst_buf <= imem_rdata;
            r_state    <= ST_VALID;
            r_imem_req <= 1'b0;
          end else if (branch_taken && !imem_ack) begin
            // the in-flight read must still complete before redirecting
            r_target <= branch_addr;
            r_state  <= ST_DROP;
          end else if (branch_taken && imem_ack) begin
            r_req_addr <= branch_addr;
          end
        end
        ST_VALID: begin
          if (branch_taken) begin
            r_req_addr <= branch_addr;
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else if (!freeze) begin
            r_req_addr <= r_req_addr + 32'd4;
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            r_req_addr <= branch_taken ? branch_addr : r_target;
            r_state    <= ST_FETCH;
          end else if (branch_taken) begin
            r_target <= branch_addr;
          end
        end
        default: begin
          r_state    <= ST_START;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  // a redirect suppresses the buffered instruction in the same cycle
  assign w_valid         = (r_state == ST_VALID) && !branch_taken;
  assign inst_valid      = w_valid;
  assign Instruction_out = w_valid ? r_inst_buf : 32'h0;
  assign PC_out          = r_req_addr + 32'd4;
  assign imem_req        = r_imem_req;
  assign imem_addr       = r_req_addr;

endmodule
`default_nettype wire
